// File: rtl/checkpoint_seq_monitor.sv
// Firmware progress monitor: follows a programmed sequence of checkpoint codes on a
// watched bus, with per-step timeout, abort-code detection and a stability filter.
module checkpoint_seq_monitor #(
    parameter int CODE_W        = 16,
    parameter int NUM_STEPS     = 8,
    parameter int TIMER_W       = 20,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                         clock,
    input  logic                         resetb,
    input  logic [CODE_W-1:0]            chk_bus,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_STEPS)-1:0] cfg_idx,
    input  logic [CODE_W-1:0]            cfg_code,
    input  logic [$clog2(NUM_STEPS):0]   num_steps,
    input  logic [CODE_W-1:0]            fail_code,
    input  logic                         fail_en,
    input  logic [TIMER_W-1:0]           timeout_lim,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic [$clog2(NUM_STEPS)-1:0] cur_step,
    output logic [TIMER_W-1:0]           step_cycles
);

    localparam int IDX_W  = $clog2(NUM_STEPS);
    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0]  STAB_LAST   = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [IDX_W:0]     NUM_STEPS_C = (IDX_W + 1)'(NUM_STEPS);
    localparam logic [TIMER_W-1:0] TIMER_MAX   = {TIMER_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   chk_q;
    logic [CODE_W-1:0]   table_q [NUM_STEPS];
    logic [CODE_W-1:0]   table_d [NUM_STEPS];
    logic [IDX_W-1:0]    step_q, step_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [STAB_W-1:0]   stab_q, stab_d;
    logic [TIMER_W-1:0]  step_cycles_q, step_cycles_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                timeout_q, timeout_d;
    logic [IDX_W-1:0]    last_step_s;
    logic                code_hit_s;

    // Index of the final active step: a count of 0 means one step, oversize counts clamp.
    function automatic logic [IDX_W-1:0] last_step_f(input logic [IDX_W:0] n);
        logic [IDX_W:0] eff;
        if (n == '0) begin
            eff = {{IDX_W{1'b0}}, 1'b1};
        end else if (n > NUM_STEPS_C) begin
            eff = NUM_STEPS_C;
        end else begin
            eff = n;
        end
        last_step_f = IDX_W'(eff - {{IDX_W{1'b0}}, 1'b1});
    endfunction

    assign last_step_s = last_step_f(num_steps);
    assign code_hit_s  = (chk_q == table_q[step_q]);

    // Expected-code table: writable only while no run is in progress.
    always_comb begin
        table_d = table_q;
        if (cfg_we && (state_q != ST_WAIT)) begin
            table_d[cfg_idx] = cfg_code;
        end else begin
            table_d = table_q;
        end
    end

    // Sequencer next state: abort beats start, then WAIT evaluates accept/match/fail/timeout.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        timer_d       = timer_q;
        stab_d        = stab_q;
        step_cycles_d = step_cycles_q;
        if (abort) begin
            state_d = ST_IDLE;
            step_d  = '0;
            timer_d = '0;
            stab_d  = '0;
        end else if (start && (state_q != ST_WAIT)) begin
            state_d = ST_WAIT;
            step_d  = '0;
            timer_d = '0;
            stab_d  = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (code_hit_s) begin
                        if (stab_q == STAB_LAST) begin
                            step_cycles_d = timer_q;
                            if (step_q == last_step_s) begin
                                state_d = ST_PASS;
                            end else begin
                                step_d  = step_q + 1'b1;
                                timer_d = '0;
                                stab_d  = '0;
                            end
                        end else begin
                            stab_d = stab_q + 1'b1;
                        end
                    end else begin
                        // A matching sample never counts toward fail or timeout.
                        stab_d = '0;
                        if (fail_en && (chk_q == fail_code)) begin
                            state_d = ST_FAIL;
                        end else if ((timeout_lim != '0) && (timer_q == timeout_lim)) begin
                            state_d = ST_TIMEOUT;
                        end else if (timer_q != TIMER_MAX) begin
                            timer_d = timer_q + 1'b1;
                        end else begin
                            timer_d = timer_q;
                        end
                    end
                end
                ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Status flags decoded from the next state so they come straight out of flops.
    always_comb begin
        busy_d    = (state_d == ST_WAIT);
        pass_d    = (state_d == ST_PASS);
        fail_d    = (state_d == ST_FAIL);
        timeout_d = (state_d == ST_TIMEOUT);
        done_d    = pass_d | fail_d | timeout_d;
    end

    // State, table, bus sample and status registers.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q       <= ST_IDLE;
            chk_q         <= '0;
            table_q       <= '{default: '0};
            step_q        <= '0;
            timer_q       <= '0;
            stab_q        <= '0;
            step_cycles_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            chk_q         <= chk_bus;
            table_q       <= table_d;
            step_q        <= step_d;
            timer_q       <= timer_d;
            stab_q        <= stab_d;
            step_cycles_q <= step_cycles_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign cur_step    = step_q;
    assign step_cycles = step_cycles_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Bench for checkpoint_seq_monitor: directed scenarios plus random traffic, all compared
// every cycle against a sequence-level reference model.
module tb_checkpoint_seq_monitor;

    localparam int CODE_W    = 16;
    localparam int NUM_STEPS = 8;
    localparam int TIMER_W   = 20;
    localparam int STABLE    = 2;
    localparam int IDX_W     = $clog2(NUM_STEPS);
    localparam int TMAX      = (1 << TIMER_W) - 1;
    localparam int S_IDLE = 0, S_WAIT = 1, S_PASS = 2, S_FAIL = 3, S_TOUT = 4;

    logic               clock = 1'b0;
    logic               resetb = 1'b0;
    logic [CODE_W-1:0]  chk_bus = '0;
    logic               cfg_we = 1'b0;
    logic [IDX_W-1:0]   cfg_idx = '0;
    logic [CODE_W-1:0]  cfg_code = '0;
    logic [IDX_W:0]     num_steps = '0;
    logic [CODE_W-1:0]  fail_code = '0;
    logic               fail_en = 1'b0;
    logic [TIMER_W-1:0] timeout_lim = '0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               busy, done, pass, fail, timeout;
    logic [IDX_W-1:0]   cur_step;
    logic [TIMER_W-1:0] step_cycles;

    int checks = 0;
    int errors = 0;
    int cnt;

    checkpoint_seq_monitor #(
        .CODE_W(CODE_W), .NUM_STEPS(NUM_STEPS), .TIMER_W(TIMER_W), .STABLE_CYCLES(STABLE)
    ) dut (
        .clock(clock), .resetb(resetb), .chk_bus(chk_bus), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_code(cfg_code), .num_steps(num_steps),
        .fail_code(fail_code), .fail_en(fail_en), .timeout_lim(timeout_lim),
        .start(start), .abort(abort), .busy(busy), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .cur_step(cur_step), .step_cycles(step_cycles)
    );

    always #5 clock = ~clock;

    // Reference model: run phase, step being waited on, cycles spent, length of the
    // current run of matching samples, and the timer captured at the last acceptance.
    typedef struct packed {
        int st;
        int step;
        int timer;
        int run;
        int sc;
    } mst_t;

    mst_t              m;
    logic [CODE_W-1:0] m_tab [NUM_STEPS];
    logic [CODE_W-1:0] m_chk;

    function automatic int eff_steps(input logic [IDX_W:0] n);
        if (n == 0) return 1;
        if (n > NUM_STEPS) return NUM_STEPS;
        return int'(n);
    endfunction

    function automatic mst_t model_next(input mst_t c);
        mst_t n = c;
        if (abort) begin
            n.st = S_IDLE; n.step = 0; n.timer = 0; n.run = 0;
        end else if (start && c.st != S_WAIT) begin
            n.st = S_WAIT; n.step = 0; n.timer = 0; n.run = 0;
        end else if (c.st == S_WAIT) begin
            if (m_chk == m_tab[c.step]) begin
                if (c.run + 1 >= STABLE) begin
                    n.sc = c.timer;
                    if (c.step == eff_steps(num_steps) - 1) n.st = S_PASS;
                    else begin n.step = c.step + 1; n.timer = 0; n.run = 0; end
                end else begin
                    n.run = c.run + 1;
                end
            end else begin
                n.run = 0;
                if (fail_en && m_chk == fail_code) n.st = S_FAIL;
                else if (timeout_lim != 0 && c.timer == int'(timeout_lim)) n.st = S_TOUT;
                else if (c.timer < TMAX) n.timer = c.timer + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            m     <= '0;
            m_chk <= '0;
            m_tab <= '{default: '0};
        end else begin
            m     <= model_next(m);
            m_chk <= chk_bus;
            if (cfg_we && m.st != S_WAIT) m_tab[cfg_idx] <= cfg_code;
        end
    end

    task automatic tick();
        logic [4:0] exp_f, act_f;
        @(negedge clock);
        exp_f = {m.st == S_WAIT, m.st >= S_PASS, m.st == S_PASS, m.st == S_FAIL, m.st == S_TOUT};
        act_f = {busy, done, pass, fail, timeout};
        checks++;
        if (act_f !== exp_f || cur_step !== IDX_W'(m.step) || step_cycles !== TIMER_W'(m.sc)) begin
            errors++;
            $display("FAIL model_cmp t=%0t flags=%b exp=%b cur_step=%0d exp=%0d step_cycles=%0d exp=%0d",
                     $time, act_f, exp_f, cur_step, m.step, step_cycles, m.sc);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic load_table();
        logic [CODE_W-1:0] codes [4];
        codes = '{16'hAB40, 16'hAB41, 16'hAB42, 16'hAB51};
        for (int i = 0; i < 4; i++) begin
            cfg_we = 1'b1; cfg_idx = IDX_W'(i); cfg_code = codes[i];
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic arm(input logic [CODE_W-1:0] code);
        chk_bus = code; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_step(input int s);
        for (int i = 0; i < 40 && int'(cur_step) != s; i++) tick();
    endtask

    initial begin
        logic [CODE_W-1:0] alpha [5];
        int r;
        alpha = '{16'hAB40, 16'hAB41, 16'hAB42, 16'hAB43, 16'h0000};

        tick_n(3);
        pin("reset_flags", 32'({busy, done, pass, fail, timeout}), 32'd0);
        pin("reset_step", 32'(cur_step), 32'd0);
        pin("reset_sc", 32'(step_cycles), 32'd0);
        resetb = 1'b1;
        num_steps = 4'd4; timeout_lim = 20'd1000; fail_code = 16'hAB44; fail_en = 1'b0;
        load_table();

        // Full pass, each code held 10 cycles.
        arm(16'hAB40); tick_n(9);
        chk_bus = 16'hAB41; tick_n(10);
        chk_bus = 16'hAB42; tick_n(10);
        chk_bus = 16'hAB51; tick_n(2);
        pin("pass_early", 32'(pass), 32'd0);
        tick();
        pin("pass_on_time", 32'(pass), 32'd1);
        tick_n(7);
        pin("pass_step", 32'(cur_step), 32'd3);
        pin("pass_ft", 32'({fail, timeout}), 32'd0);
        pin("pass_sc", 32'(step_cycles), 32'd8);

        // Restart from PASS, then fail code abort.
        arm(16'hAB40);
        pin("restart_busy", 32'(busy), 32'd1);
        pin("restart_step", 32'(cur_step), 32'd0);
        fail_en = 1'b1;
        tick_n(9);
        chk_bus = 16'hAB44; tick_n(5);
        pin("fail_flag", 32'(fail), 32'd1);
        pin("fail_step", 32'(cur_step), 32'd1);

        // Same with fail detection off: timeout instead.
        fail_en = 1'b0;
        arm(16'hAB40); tick_n(9);
        chk_bus = 16'hAB44;
        for (int i = 0; i < 1200 && !timeout; i++) tick();
        pin("tout_flag", 32'(timeout), 32'd1);
        pin("tout_nofail", 32'(fail), 32'd0);
        pin("tout_step", 32'(cur_step), 32'd1);

        // Timeout latency with lim=50, measured from step-1 entry.
        timeout_lim = 20'd50;
        arm(16'hAB40);
        wait_step(1);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick(); cnt++;
            if (timeout) break;
        end
        pin("tout_latency", 32'(cnt), 32'd51);

        // lim=0 never times out.
        timeout_lim = 20'd0;
        arm(16'hAB40); tick_n(5000);
        pin("nolim_busy", 32'(busy), 32'd1);
        pin("nolim_tout", 32'(timeout), 32'd0);

        // Glitch filter.
        do_abort();
        timeout_lim = 20'd1000;
        arm(16'hAB40);
        wait_step(1);
        chk_bus = 16'hAB41; tick();
        chk_bus = 16'h0000; tick_n(5);
        pin("glitch_reject", 32'(cur_step), 32'd1);
        chk_bus = 16'hAB41; tick_n(2);
        chk_bus = 16'h0000; tick_n(3);
        pin("hold_accept", 32'(cur_step), 32'd2);

        // Accept wins over timeout when the match lands as the timer reaches the limit.
        do_abort();
        timeout_lim = 20'd20;
        arm(16'hAB40);
        wait_step(1);
        tick_n(19);
        chk_bus = 16'hAB41; tick_n(3);
        pin("race_tout", 32'(timeout), 32'd0);
        pin("race_step", 32'(cur_step), 32'd2);
        pin("race_sc", 32'(step_cycles), 32'd20);

        // Async reset mid-WAIT at step 2.
        do_abort();
        timeout_lim = 20'd1000;
        arm(16'hAB40); tick_n(9);
        chk_bus = 16'hAB41; tick_n(10);
        #2 resetb = 1'b0;
        #1;
        pin("async_flags", 32'({busy, done, pass, fail, timeout}), 32'd0);
        pin("async_step", 32'(cur_step), 32'd0);
        pin("async_sc", 32'(step_cycles), 32'd0);
        tick();
        resetb = 1'b1;
        tick_n(3);
        pin("rearm_needed", 32'(busy), 32'd0);
        load_table();

        // Table write ignored in WAIT; abort beats start.
        arm(16'h0000);
        cfg_we = 1'b1; cfg_idx = '0; cfg_code = 16'h1234; tick();
        cfg_we = 1'b0;
        chk_bus = 16'hAB40; tick_n(5);
        pin("we_in_wait", 32'(cur_step), 32'd1);
        abort = 1'b1; start = 1'b1; tick();
        abort = 1'b0; start = 1'b0;
        pin("abort_start", 32'({busy, done, cur_step}), 32'd0);

        // Random traffic; configuration changes only together with abort.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                abort = 1'b1;
                num_steps = 4'($urandom_range(0, 15));
                timeout_lim = 20'($urandom_range(0, 60));
                fail_en = 1'($urandom_range(0, 1));
                fail_code = alpha[$urandom_range(0, 4)];
            end else if (r < 6) begin
                start = 1'b1;
            end else if (r < 12) begin
                cfg_we = 1'b1;
                cfg_idx = IDX_W'($urandom_range(0, NUM_STEPS - 1));
                cfg_code = alpha[$urandom_range(0, 3)];
            end
            if ($urandom_range(0, 9) < 3) chk_bus = alpha[$urandom_range(0, 4)];
            tick();
            abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/checkpoint_seq_monitor.md
Name: checkpoint_seq_monitor

Overview:
Synthesizable monitor that watches a firmware progress bus (e.g. checkbits on mprj_io[31:16]) and checks that it steps through a programmed sequence of checkpoint codes. Each step has a timeout, a fail code that aborts the run, and a stability filter. It replaces hand-written wait() chains in benches and gives silicon a pass/fail/timeout status readable over the logic analyser. It generalises the fixed 16-bit, fixed-sequence check to a parametrised width and depth with timeout and fail detection.

Parameters:
CODE_W, 16, width of the watched progress bus and of every code
NUM_STEPS, 8, depth of the expected-code table
TIMER_W, 20, width of the per-step cycle timer
STABLE_CYCLES, 2, consecutive matching samples required to accept a code (>=1)

Ports:
clock  in  1  single clock
resetb  in  1  asynchronous active-low reset
chk_bus  in  CODE_W  watched progress bus (may be asynchronous; sampled once)
cfg_we  in  1  table write strobe
cfg_idx  in  $clog2(NUM_STEPS)  table write index
cfg_code  in  CODE_W  expected code for cfg_idx
num_steps  in  $clog2(NUM_STEPS)+1  active step count; 0 treated as 1, >NUM_STEPS clamped
fail_code  in  CODE_W  abort code
fail_en  in  1  enables fail_code detection
timeout_lim  in  TIMER_W  per-step limit in cycles; 0 = no timeout
start  in  1  pulse: arm / re-arm
abort  in  1  pulse: return to IDLE
busy  out  1  high in WAIT
done  out  1  high in PASS, FAIL or TIMEOUT
pass  out  1  high in PASS
fail  out  1  high in FAIL
timeout  out  1  high in TIMEOUT
cur_step  out  $clog2(NUM_STEPS)  step being waited on, or final step
step_cycles  out  TIMER_W  timer value at the last step acceptance

Behaviour:
- Reset: state IDLE; all outputs 0; table entries, chk_q, timer and stab_cnt 0.
- chk_bus registered once into chk_q every cycle; all compares use chk_q.
- States: IDLE, WAIT, PASS, FAIL, TIMEOUT. done/pass/fail/timeout/busy are decoded from registered state, no combinational path from inputs.
- Table writes take effect when cfg_we=1 in IDLE/PASS/FAIL/TIMEOUT; ignored in WAIT.
- start in any state except WAIT: step=0, timer=0, stab_cnt=0, go to WAIT next edge. start in WAIT is ignored.
- abort in any state: go to IDLE, clear step/timer/stab_cnt. abort beats start on the same cycle.
- WAIT, evaluated each edge in priority order:
  1) accept: chk_q==table[step] and stab_cnt==STABLE_CYCLES-1. Capture step_cycles=timer. If step==eff_steps-1, go to PASS; else step+1, timer=0, stab_cnt=0.
  2) chk_q==table[step] otherwise: stab_cnt+1.
  3) fail_en and chk_q==fail_code (and not equal to table[step]): go to FAIL; cur_step holds the step.
  4) timeout_lim!=0 and timer==timeout_lim: go to TIMEOUT.
  5) else timer+1, saturating at all-ones. Any non-match clears stab_cnt.
- Acceptance has priority over fail and timeout in the same cycle.
- Latency: chk_bus is stable from before edge k. chk_q is valid after edge k. The step advances at edge k+STABLE_CYCLES.
- A glitch shorter than STABLE_CYCLES samples is never accepted.
- Repeated codes in consecutive entries each need a fresh STABLE_CYCLES window after the step advance.
- Terminal states hold until start or abort. A later change on chk_bus has no effect.

Test Plan:
- CODE_W=16, table {AB40,AB41,AB42,AB51}, num_steps=4, STABLE=2, lim=1000. Drive each code for 10 cycles in order -> pass=1 two cycles after AB51 is stable; cur_step=3; fail=timeout=0.
- Same table; drive AB40 then AB44 with fail_code=AB44, fail_en=1 -> fail=1 with cur_step=1. Repeat with fail_en=0 -> no fail, then TIMEOUT after 1000 cycles.
- lim=50; hold AB40 only -> step 1 entered, timeout=1 exactly 51 cycles after step-1 entry. lim=0 -> no timeout after 10^6 cycles, busy stays 1.
- STABLE=2; 1-cycle glitch to AB41 while waiting on step 1 -> no advance; a 2-cycle hold -> advance. AB41 present on the same edge the timer hits the limit -> accepted, no timeout.
- Assert resetb low mid-WAIT at step 2 -> all outputs 0 immediately (async). After release, start is needed to re-arm.
- cfg_we during WAIT -> table unchanged; abort+start on the same cycle -> IDLE; start while in PASS -> restart at step 0.
